// File: rtl/board_manager.sv
// Settled-block grid manager: merges a locked piece, clears full rows by
// bottom-up scan-and-shift, and tracks line statistics and game-over.
module board_manager #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       lock_req,
  input  logic                       clear_board,
  input  logic [ROWS-1:0][COLS-1:0]  currBlocks,
  output logic [ROWS-1:0][COLS-1:0]  fallenBlocks,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 lines_cleared,
  output logic [15:0]                score_lines,
  output logic                       top_out
);

  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(ROWS + 1);
  localparam logic [PW-1:0] PTR_TOP = PW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   line_cnt;
  logic            overlap;
  logic            row_full;
  logic [16:0]     score_sum;
  logic [15:0]     score_next;
  logic [2:0]      lines_next;

  assign row_full = &fallenBlocks[ptr];

  // A single lock can clear more rows than the 3-bit report holds, so the
  // report saturates while the running score takes the full count.
  always_comb begin
    score_sum  = {1'b0, score_lines} + 17'(line_cnt);
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    lines_next = (int'(line_cnt) > 7) ? 3'd7 : 3'(line_cnt);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      fallenBlocks  <= '0;
      ptr           <= PTR_TOP;
      line_cnt      <= '0;
      overlap       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= 3'd0;
      score_lines   <= 16'd0;
      top_out       <= 1'b0;
    end else if (clear_board) begin
      state         <= IDLE;
      fallenBlocks  <= '0;
      overlap       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= 3'd0;
      score_lines   <= 16'd0;
      top_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_req) begin
            fallenBlocks <= fallenBlocks | currBlocks;
            overlap      <= overlap | (|(fallenBlocks & currBlocks));
            ptr          <= PTR_TOP;
            line_cnt     <= '0;
            state        <= SCAN;
            busy         <= 1'b1;
          end
        end

        SCAN: begin
          if (row_full) begin
            state <= SHIFT;
          end else if (ptr != '0) begin
            ptr <= ptr - 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        // Everything above the full row drops by one; the row is rescanned
        // since the row that slid into it may be full as well.
        SHIFT: begin
          for (int k = 1; k < ROWS; k++) begin
            if (k <= int'(ptr)) begin
              fallenBlocks[k] <= fallenBlocks[k-1];
            end
          end
          fallenBlocks[0] <= '0;
          line_cnt        <= line_cnt + 1'b1;
          state           <= SCAN;
        end

        DONE: begin
          lines_cleared <= lines_next;
          score_lines   <= score_next;
          top_out       <= top_out | overlap | (|fallenBlocks[0]);
          state         <= IDLE;
          busy          <= 1'b0;
          done          <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/board_manager.md
BOARD_MANAGER -- requirements
Module: board_manager

Interface
REQ-001 SHALL have parameter ROWS, default 20, meaning playfield rows (row 0 = top).
REQ-002 SHALL have parameter COLS, default 10, meaning playfield columns (col 0 = left).
REQ-003 SHALL have port Clk  in  1  meaning the single system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset_n  in  1  meaning the reset: asynchronous, active-low.
REQ-005 SHALL have port lock_req  in  1  meaning a one-cycle request to merge the active piece into the settled grid.
REQ-006 SHALL have port clear_board  in  1  meaning a synchronous request to empty the board and statistics.
REQ-007 SHALL have port currBlocks  in  [COLS-1:0] x ROWS  meaning the active-piece occupancy; bit [i][j] = row i, col j.
REQ-008 SHALL have port fallenBlocks  out  [COLS-1:0] x ROWS  meaning the settled-block grid consumed by the renderer, same indexing.
REQ-009 SHALL have port busy  out  1  meaning high in every state except IDLE.
REQ-010 SHALL have port done  out  1  meaning a one-cycle pulse at completion of a lock.
REQ-011 SHALL have port lines_cleared  out  3  meaning the lines removed by the last completed lock (0-4).
REQ-012 SHALL have port score_lines  out  16  meaning the total lines cleared, saturating.
REQ-013 SHALL have port top_out  out  1  meaning a sticky game-over flag.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, SHIFT, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-015 In IDLE with lock_req=1 and clear_board=0, the same edge SHALL set fallenBlocks <= fallenBlocks | currBlocks, set row pointer to ROWS-1, zero the internal line counter, and go to SCAN.
REQ-016 In the REQ-015 merge edge, any bit set in both fallenBlocks and currBlocks SHALL set an internal overlap flag.
REQ-017 In SCAN, if row[ptr] is all ones, the FSM SHALL go to SHIFT without changing ptr.
REQ-018 In SCAN, if row[ptr] is not full and ptr != 0, ptr SHALL decrement and the FSM SHALL stay in SCAN.
REQ-019 In SCAN, if row[ptr] is not full and ptr == 0, the FSM SHALL go to DONE.
REQ-020 In SHIFT, one edge SHALL copy row k-1 into row k for every k in 1..ptr and zero row 0; rows below ptr SHALL be unchanged; the line counter SHALL increment; the FSM SHALL return to SCAN at the same ptr.
REQ-021 A full row 0 SHALL be cleared by SHIFT, then rescanned as empty, then the FSM SHALL go to DONE.
REQ-022 At the DONE edge, lines_cleared SHALL load the line counter.
REQ-023 At the DONE edge, score_lines SHALL add the line counter, saturating at 16'hFFFF.
REQ-024 At the DONE edge, top_out SHALL be set if the overlap flag is set or row 0 is nonzero; the FSM SHALL then go to IDLE.
REQ-025 Latency: done SHALL be high in the cycle after edge ROWS+2L, counted from the lock_req sampling edge (edge 0), where L = lines cleared; for ROWS=20 that is 20/22/28 edges for L=0/1/4.
REQ-026 lock_req while busy SHALL be ignored; it is not queued.
REQ-027 currBlocks SHALL be sampled only at the merge edge.
REQ-028 clear_board=1 in any state SHALL, at that edge, zero fallenBlocks, lines_cleared, score_lines, top_out and the overlap flag, and go to IDLE; it aborts any lock in progress, and no done pulse SHALL follow.
REQ-029 clear_board SHALL take priority over a simultaneous lock_req.
REQ-030 top_out SHALL be cleared only by reset or clear_board.
REQ-031 top_out SHALL NOT block further locks.

Reset
REQ-032 Reset_n=0 SHALL asynchronously force state IDLE, fallenBlocks all zero, ptr=ROWS-1, line counter 0, overlap 0, busy 0, done 0, lines_cleared 0, score_lines 0, top_out 0.
REQ-033 Reset_n asserted mid-operation SHALL abandon the lock with no done pulse.
REQ-034 Reset_n deassertion SHALL be synchronized to Clk by the instantiating top level.

Verification
REQ-035 Reset: assert Reset_n=0 mid-SHIFT -> all outputs zero immediately; after release, IDLE and busy=0.
REQ-036 Empty board, lock currBlocks rows 18-19 cols 4-5 -> fallenBlocks equals that pattern; done in the cycle after edge 20; lines_cleared=0; score_lines=0.
REQ-037 Row 19 cols 0-8 set, row 18 col 0 set; lock piece {row19 col9, row18 col9} -> row 19 = 10'b1000000001 (cols 0 and 9), rows 0-18 empty; lines_cleared=1; done in the cycle after edge 22; score_lines=1.
REQ-038 Rows 16-19 full after merge (I-piece in col 9) -> rows 16-19 empty; lines_cleared=4; done in the cycle after edge 28; score_lines increases by 4; preload 16'hFFFE -> saturates to 16'hFFFF.
REQ-039 Lock a piece overlapping a settled bit -> top_out=1 at DONE; top_out stays 1 across a later clean lock; clear_board -> top_out=0, grid zero.
REQ-040 lock_req pulsed during SCAN -> ignored and grid unchanged by it; clear_board during SCAN -> next cycle busy=0, no done pulse, grid zero.
